multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the 8-bit, four-register datapath. It decodes the 8-bit instruction held in the IR. It steps the shared ALU, register file and unified memory through fetch, decode, execute, memory and writeback. It handshakes with memory via req/ready, honours a halt request at instruction boundaries, and counts retired instructions. The datapath, IR, PC and sign-extension unit sit outside the block; this block only drives their selects and enables.

## Interface
Parameters:
- CNT_W, default 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- instr, input, 8: IR contents, with opcode [7:6], rs [5:4], rt [3:2], rd/imm [1:0]. Stable from ID onward.
- mem_ready, input, 1: memory completes the current request in this cycle.
- halt, input, 1: stop request, sampled only at instruction boundaries.
- mem_req, output, 1: memory access request.
- mem_we, output, 1: memory write, valid only while mem_req=1.
- iord, output, 1: memory address select; 0 selects PC, 1 selects ALUOut.
- ir_write, output, 1: IR load enable.
- pc_write, output, 1: PC load enable.
- pc_src, output, 1: PC source; 0 selects ALU result, 1 selects the jump target.
- alu_src_a, output, 1: ALU input A; 0 selects PC, 1 selects reg[rs].
- alu_src_b, output, 2: ALU input B; 00 selects reg[rt], 01 selects constant 1, 10 selects sign-extended imm. 11 is unused and never driven.
- reg_write, output, 1: register file write enable.
- reg_dst, output, 1: write-register select; 0 selects rt, 1 selects rd.
- mem_to_reg, output, 1: write-data select; 0 selects ALUOut, 1 selects MDR.
- state, output, 3: current state, for debug.
- num_inst, output, CNT_W: retired-instruction count.

## Operation
- Opcodes:
  - 00 ADD: rd ← rs + rt.
  - 01 LW: rt ← mem[rs + sext(imm)].
  - 10 SW: mem[rs + sext(imm)] ← rt.
  - 11 JMP: the datapath forms the jump target.
- State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5. Values 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs are Moore-decoded from state and instr[7:6]. The only exception is ir_write and pc_write in IF, which are additionally ANDed with mem_ready.
- Any output not listed for a state below is 0.
- IDLE: all outputs 0. Go to IF when halt=0, otherwise stay.
- IF: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01.
  - ir_write and pc_write equal mem_ready.
  - Stay in IF while mem_ready=0; go to ID on mem_ready=1.
- ID:
  - opcode 11: pc_write=1, pc_src=1. Instruction retires.
  - opcode 00, 01 or 10: go to EX.
- EX:
  - ADD: alu_src_a=1, alu_src_b=00, then go to WB.
  - LW and SW: alu_src_a=1, alu_src_b=10, then go to MEM.
- MEM: mem_req=1, iord=1, mem_we=1 for SW only.
  - Hold all outputs while mem_ready=0.
  - On mem_ready=1: LW goes to WB; SW retires.
- WB: reg_write=1.
  - ADD: reg_dst=1, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - Instruction retires.
- Retire: num_inst increments by 1, wrapping modulo 2^CNT_W. Next state is IDLE if halt=1, otherwise IF.
- halt is ignored in every state except the retire transition and IDLE.
- A mem_ready pulse is ignored in ID, EX and WB.

## Timing
- While reset_n=0, asynchronously: state=IDLE, num_inst=0, all control outputs 0.
- After reset_n deasserts, the first rising edge with halt=0 moves to IF, so mem_req=1 one cycle after release.
- With zero-wait memory (mem_ready=1 in the first request cycle):
  - JMP: 2 cycles (IF, ID).
  - ADD: 4 cycles (IF, ID, EX, WB).
  - SW: 4 cycles (IF, ID, EX, MEM).
  - LW: 5 cycles (IF, ID, EX, MEM, WB).
- Each wait cycle on mem_ready in IF or MEM adds 1 cycle to the instruction.
- mem_req stays high continuously through waits; addresses and selects are held constant.
- num_inst updates on the same edge that leaves the retiring state. The new value is visible in the first cycle of the next IF or IDLE.
- A retiring instruction is followed directly by IF with no IDLE bubble unless halt=1.
- If reset_n asserts mid-instruction, the instruction is abandoned: no further writes, num_inst is cleared, and state is IDLE.

## Test plan
- Reset, then halt=0 and mem_ready tied 1: state sequence 0→1 (mem_req=1, iord=0, ir_write=1, pc_write=1)→2. Instructions issued: ADD 0x1B (rs=1, rt=2, rd=3), SW, JMP.
  - ADD 0x1B: EX shows alu_src_a=1, alu_src_b=00; WB shows reg_write=1, reg_dst=1.
  - num_inst=1 after 4 cycles.
- LW 0x47 (rs=0, rt=1, imm=11) with 2 wait cycles in both IF and MEM:
  - Takes 9 cycles.
  - ir_write pulses exactly once.
  - MEM holds mem_req=1, iord=1, mem_we=0 for 3 cycles.
  - WB shows reg_dst=0, mem_to_reg=1.
- SW 0x86: MEM asserts mem_we=1 only while mem_req=1, then returns to IF with reg_write never asserted. JMP 0xC5: ID asserts pc_write=1, pc_src=1; total 2 cycles.
- halt=1 raised during EX of an ADD: WB completes, num_inst increments, state goes to IDLE and stays there. Dropping halt gives IF on the next edge.
- reset_n pulsed low asynchronously mid-MEM of an SW with num_inst=5:
  - Outputs go to 0 immediately, with no clock edge needed.
  - num_inst=0 and state=0.
- num_inst preloaded by running 65535 JMPs: the next retire wraps num_inst to 0x0000.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: sequences fetch/decode/execute/mem/writeback for the
// 8-bit four-register datapath and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] num_inst
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  op_t              w_op;
  logic             w_retire;

  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_iord;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_pc_src;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic             w_reg_write;
  logic             w_reg_dst;
  logic             w_mem_to_reg;

  assign w_op = op_t'(instr[7:6]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_retire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = S_IDLE;
    w_retire     = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = halt ? S_IDLE : S_IF;
      end
      S_IF: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        w_next      = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        if (w_op == OP_JMP) begin
          w_pc_write = 1'b1;
          w_pc_src   = 1'b1;
          w_retire   = 1'b1;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        w_alu_src_a = 1'b1;
        if (w_op == OP_ADD) begin
          w_alu_src_b = 2'b00;
          w_next      = S_WB;
        end else begin
          w_alu_src_b = 2'b10;
          w_next      = S_MEM;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (w_op == OP_SW);
        w_next    = S_MEM;
        if (mem_ready) begin
          if (w_op == OP_SW) begin
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        if (w_op == OP_LW) begin
          w_mem_to_reg = 1'b1;
        end else begin
          w_reg_dst = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // retire is the only boundary where halt is honoured mid-stream
    if (w_retire) begin
      w_next = halt ? S_IDLE : S_IF;
    end
  end

  assign mem_req    = w_mem_req;
  assign mem_we     = w_mem_we;
  assign iord       = w_iord;
  assign ir_write   = w_ir_write;
  assign pc_write   = w_pc_write;
  assign pc_src     = w_pc_src;
  assign alu_src_a  = w_alu_src_a;
  assign alu_src_b  = w_alu_src_b;
  assign reg_write  = w_reg_write;
  assign reg_dst    = w_reg_dst;
  assign mem_to_reg = w_mem_to_reg;
  assign state      = r_state;
  assign num_inst   = r_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors queued
// by stimulus, popped and compared by an independent monitor.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  instr;
  logic        mem_ready;
  logic        halt;

  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic [1:0]  alu_src_b;
  logic [2:0]  state;
  logic [15:0] num_inst;

  logic        n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_src;
  logic        n_alu_src_a, n_reg_write, n_reg_dst, n_mem_to_reg;
  logic [1:0]  n_alu_src_b;
  logic [2:0]  n_state;
  logic [3:0]  n_num_inst;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr),
    .mem_ready(mem_ready), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .num_inst(num_inst)
  );

  // narrow counter copy makes the wrap boundary reachable quickly
  multicycle_control #(.CNT_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .instr(instr),
    .mem_ready(mem_ready), .halt(halt),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord),
    .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .reg_write(n_reg_write), .reg_dst(n_reg_dst),
    .mem_to_reg(n_mem_to_reg), .state(n_state), .num_inst(n_num_inst)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [15:0] cnt;
  } obs_t;

  // ctl = {req,we,iord,irw,pcw,pcsrc,asa,asb[1:0],rw,rdst,m2r}
  localparam logic [11:0] C_ZERO = 12'h000;
  localparam logic [11:0] C_IF1  = 12'h988;
  localparam logic [11:0] C_IF0  = 12'h808;
  localparam logic [11:0] C_IDJ  = 12'h0C0;
  localparam logic [11:0] C_EXA  = 12'h020;
  localparam logic [11:0] C_EXM  = 12'h030;
  localparam logic [11:0] C_MLW  = 12'hA00;
  localparam logic [11:0] C_MSW  = 12'hE00;
  localparam logic [11:0] C_WBA  = 12'h006;
  localparam logic [11:0] C_WBL  = 12'h005;

  obs_t        q[$];
  string       nq[$];
  logic [15:0] ecnt = 16'd0;
  logic        samp = 1'b0;
  int          total = 0;
  int          bad = 0;

  obs_t        e_obs;
  obs_t        g_obs;
  string       e_name;

  always @(negedge clk or posedge samp) begin
    if (q.size() > 0) begin
      e_obs  = q.pop_front();
      e_name = nq.pop_front();
      g_obs  = {state, mem_req, mem_we, iord, ir_write, pc_write,
                pc_src, alu_src_a, alu_src_b, reg_write, reg_dst,
                mem_to_reg, num_inst};
      total++;
      if (g_obs !== e_obs || n_num_inst !== e_obs.cnt[3:0]) begin
        bad++;
        $display("FAIL %s: got st=%0d ctl=%h cnt=%h cnt4=%h want st=%0d ctl=%h cnt=%h cnt4=%h",
                 e_name, g_obs.st, g_obs.ctl, g_obs.cnt, n_num_inst,
                 e_obs.st, e_obs.ctl, e_obs.cnt, e_obs.cnt[3:0]);
      end
    end
  end

  task automatic expect_now(input string n, input logic [2:0] st,
                            input logic [11:0] ctl);
    obs_t o;
    o.st  = st;
    o.ctl = ctl;
    o.cnt = ecnt;
    q.push_back(o);
    nq.push_back(n);
  endtask

  task automatic step(input string n, input logic [2:0] st,
                      input logic [11:0] ctl, input logic mr,
                      input logic h, input bit ret);
    mem_ready = mr;
    halt      = h;
    expect_now(n, st, ctl);
    @(posedge clk);
    #1;
    if (ret) ecnt = ecnt + 16'd1;
  endtask

  task automatic sample_now();
    samp = 1'b1;
    #1;
    samp = 1'b0;
  endtask

  task automatic run_jmp();
    instr = 8'hC5;
    step("jmp_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("jmp_id", 3'd2, C_IDJ, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n   = 1'b0;
    instr     = 8'h00;
    mem_ready = 1'b0;
    halt      = 1'b0;
    #3;
    expect_now("in_reset", 3'd0, C_ZERO);
    sample_now();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("idle_go", 3'd0, C_ZERO, 1'b1, 1'b0, 1'b0);

    // ADD 0x1B, zero-wait
    instr = 8'h1B;
    step("add_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("add_id", 3'd2, C_ZERO, 1'b1, 1'b0, 1'b0);
    step("add_ex", 3'd3, C_EXA, 1'b0, 1'b0, 1'b0);
    step("add_wb", 3'd5, C_WBA, 1'b1, 1'b0, 1'b1);

    // SW 0x86, zero-wait
    instr = 8'h86;
    step("sw_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("sw_id", 3'd2, C_ZERO, 1'b0, 1'b0, 1'b0);
    step("sw_ex", 3'd3, C_EXM, 1'b1, 1'b0, 1'b0);
    step("sw_mem", 3'd4, C_MSW, 1'b1, 1'b0, 1'b1);

    run_jmp();

    // LW 0x47 with two wait cycles in IF and in MEM
    instr = 8'h47;
    step("lw_if_w0", 3'd1, C_IF0, 1'b0, 1'b0, 1'b0);
    step("lw_if_w1", 3'd1, C_IF0, 1'b0, 1'b0, 1'b0);
    step("lw_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("lw_id", 3'd2, C_ZERO, 1'b1, 1'b0, 1'b0);
    step("lw_ex", 3'd3, C_EXM, 1'b1, 1'b0, 1'b0);
    step("lw_mem_w0", 3'd4, C_MLW, 1'b0, 1'b0, 1'b0);
    step("lw_mem_w1", 3'd4, C_MLW, 1'b0, 1'b0, 1'b0);
    step("lw_mem", 3'd4, C_MLW, 1'b1, 1'b0, 1'b0);
    step("lw_wb", 3'd5, C_WBL, 1'b1, 1'b0, 1'b1);

    // ADD with halt raised in EX: retires, then parks in IDLE
    instr = 8'h1B;
    step("h_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("h_id", 3'd2, C_ZERO, 1'b1, 1'b0, 1'b0);
    step("h_ex", 3'd3, C_EXA, 1'b1, 1'b1, 1'b0);
    step("h_wb", 3'd5, C_WBA, 1'b1, 1'b1, 1'b1);
    step("h_idle0", 3'd0, C_ZERO, 1'b1, 1'b1, 1'b0);
    step("h_idle1", 3'd0, C_ZERO, 1'b1, 1'b1, 1'b0);
    step("h_idle2", 3'd0, C_ZERO, 1'b1, 1'b0, 1'b0);

    // SW interrupted by async reset in MEM with five retired
    instr = 8'h86;
    step("r_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);
    step("r_id", 3'd2, C_ZERO, 1'b1, 1'b0, 1'b0);
    step("r_ex", 3'd3, C_EXM, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b0;
    expect_now("r_mem", 3'd4, C_MSW);
    sample_now();
    reset_n = 1'b0;
    #1;
    ecnt = 16'd0;
    expect_now("r_async", 3'd0, C_ZERO);
    sample_now();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("r_idle", 3'd0, C_ZERO, 1'b1, 1'b0, 1'b0);

    // 18 JMPs: narrow counter passes 15 -> 0
    for (int i = 0; i < 18; i++) run_jmp();
    instr = 8'hC5;
    step("wrap_if", 3'd1, C_IF1, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
